mem_bus_arbiter: RTL

- Shares the core's single memory bus between the fetch stage (instruction port) and the memory stage (data port).
- Registered grant FSM: latches the winning request, drives it downstream until completion, then routes the response back to its owner.
- Data port has priority (older instruction); a starvation counter guarantees forward progress for fetch.
- Sits between the pipeline front/back ends and the cache/bus interface.

---
 rtl/mem_bus_arbiter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/mem_bus_arbiter.sv
// Memory bus arbiter: shares one downstream memory port between the fetch
// stage (instruction port) and the memory stage (data port). A registered
// grant FSM latches the winning request, presents it downstream until the
// single-beat completion, and steers the response back to its owner.
// The data port normally wins because it carries the older instruction; a
// starvation counter forces an instruction grant after STARVE_LIMIT
// consecutive data grants taken while fetch was waiting.
module mem_bus_arbiter #(
  parameter int ADDR_W       = 64,
  parameter int DATA_W       = 64,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ireq_valid,
  input  logic [ADDR_W-1:0]   ireq_addr,
  input  logic [2:0]          ireq_size,
  output logic                iresp_ok,
  output logic [DATA_W-1:0]   iresp_data,
  input  logic                dreq_valid,
  input  logic [ADDR_W-1:0]   dreq_addr,
  input  logic [2:0]          dreq_size,
  input  logic [DATA_W/8-1:0] dreq_strobe,
  input  logic [DATA_W-1:0]   dreq_data,
  output logic                dresp_ok,
  output logic [DATA_W-1:0]   dresp_data,
  output logic                creq_valid,
  output logic                creq_is_write,
  output logic [ADDR_W-1:0]   creq_addr,
  output logic [2:0]          creq_size,
  output logic [DATA_W/8-1:0] creq_strobe,
  output logic [DATA_W-1:0]   creq_data,
  input  logic                cresp_ok,
  input  logic [DATA_W-1:0]   cresp_data,
  output logic                busy
);

  localparam int SW = DATA_W / 8;
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] GRANT_I = 2'd1;
  localparam logic [1:0] GRANT_D = 2'd2;

  logic [1:0]        state;
  logic [CW-1:0]     starve_cnt;
  logic              pick_d;
  logic              pick_i;
  logic [ADDR_W-1:0] lat_addr;
  logic [2:0]        lat_size;
  logic [SW-1:0]     lat_strobe;
  logic [DATA_W-1:0] lat_data;

  // Saturating increment of the starvation counter.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] cnt);
    if (cnt >= LIMIT) begin
      return LIMIT;
    end
    return cnt + 1'b1;
  endfunction

  // Arbitration decision taken in IDLE: data wins unless fetch has starved.
  always_comb begin
    pick_d = dreq_valid && ((starve_cnt < LIMIT) || !ireq_valid);
    pick_i = !pick_d && ireq_valid;
  end

  // Grant FSM, starvation counter and the latched request that drives creq_*.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      starve_cnt <= '0;
      lat_addr   <= '0;
      lat_size   <= '0;
      lat_strobe <= '0;
      lat_data   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_d) begin
            state      <= GRANT_D;
            lat_addr   <= dreq_addr;
            lat_size   <= dreq_size;
            lat_strobe <= dreq_strobe;
            lat_data   <= dreq_data;
            starve_cnt <= ireq_valid ? sat_inc(starve_cnt) : '0;
          end else if (pick_i) begin
            state      <= GRANT_I;
            lat_addr   <= ireq_addr;
            lat_size   <= ireq_size;
            lat_strobe <= '0;
            lat_data   <= '0;
            starve_cnt <= '0;
          end else begin
            starve_cnt <= '0;
          end
        end
        GRANT_I, GRANT_D: begin
          // Single-beat completion always returns through IDLE, so a new
          // grant can never follow back-to-back.
          if (cresp_ok) begin
            state      <= IDLE;
            lat_addr   <= '0;
            lat_size   <= '0;
            lat_strobe <= '0;
            lat_data   <= '0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Downstream request comes only from the latched registers.
  always_comb begin
    creq_valid    = (state != IDLE);
    busy          = (state != IDLE);
    creq_is_write = |lat_strobe;
    creq_addr     = lat_addr;
    creq_size     = lat_size;
    creq_strobe   = lat_strobe;
    creq_data     = lat_data;
  end

  // Response steering: forward completion to the owner only if it still waits.
  always_comb begin
    iresp_ok   = (state == GRANT_I) && cresp_ok && ireq_valid;
    dresp_ok   = (state == GRANT_D) && cresp_ok && dreq_valid;
    iresp_data = iresp_ok ? cresp_data : '0;
    dresp_data = dresp_ok ? cresp_data : '0;
  end

endmodule
